gol_engine: RTL and testbench

- Parametrised Conway's Game of Life engine: WIDTH x HEIGHT grid held as HEIGHT row registers of WIDTH bits.
- Replaces the per-cell gated-clock array with a single-clock, row-serial update: one row per cycle.
- Adds selectable toroidal wrap, single-step and free-run modes, a generation counter, a host write port, and a registered pixel-read port for the VGA draw logic.

---
 rtl/gol_pkg.sv | 22 ++
 rtl/gol_row_rule.sv | 31 +++
 rtl/gol_engine.sv | 170 +++++++++++++++++
 tb/tb_gol_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types, seed constants and the neighbour-count helper for the
// row-serial Game of Life engine.
package gol_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } gol_state_e;

    localparam int SEED_X = 10;
    localparam int SEED_Y = 5;

    function automatic logic [3:0] neighbour_count(input logic [7:0] nb);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, nb[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gol_row_rule.sv
// Combinational Life rule for one row, given the rows above and below.
// The edge columns read 0, or the opposite edge column when wrap is set.
module gol_row_rule
    import gol_pkg::*;
#(
    parameter int WIDTH = 50
) (
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] below,
    input  logic             wrap,
    output logic [WIDTH-1:0] next_row
);

    // Bit 0 of each padded row is column -1 and bit WIDTH+1 is column WIDTH.
    logic [WIDTH+1:0] above_p_s;
    logic [WIDTH+1:0] cur_p_s;
    logic [WIDTH+1:0] below_p_s;

    assign above_p_s = {wrap & above[0], above, wrap & above[WIDTH-1]};
    assign cur_p_s   = {wrap & cur[0],   cur,   wrap & cur[WIDTH-1]};
    assign below_p_s = {wrap & below[0], below, wrap & below[WIDTH-1]};

    for (genvar x = 0; x < WIDTH; x++) begin : g_cell
        logic [3:0] n_s;
        assign n_s = neighbour_count({above_p_s[x+2:x], cur_p_s[x+2], cur_p_s[x],
                                      below_p_s[x+2:x]});
        assign next_row[x] = (n_s == 4'd3) | (cur[x] & (n_s == 4'd2));
    end

endmodule

// File: rtl/gol_engine.sv
// Single-clock Game of Life engine: one row updated per cycle, with host
// write, seed/clear, run-rate stepping and a registered pixel read port.
module gol_engine
    import gol_pkg::*;
#(
    parameter int WIDTH  = 50,
    parameter int HEIGHT = 40,
    parameter int DIV_W  = 32,
    parameter int GEN_W  = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      step,
    input  logic                      run,
    input  logic [DIV_W-1:0]          period,
    input  logic                      wrap,
    input  logic                      seed,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [$clog2(WIDTH)-1:0]  wr_x,
    input  logic [$clog2(HEIGHT)-1:0] wr_y,
    input  logic                      wr_data,
    input  logic [$clog2(WIDTH)-1:0]  rd_x,
    input  logic [$clog2(HEIGHT)-1:0] rd_y,
    output logic                      rd_cell,
    output logic                      busy,
    output logic                      gen_done,
    output logic [GEN_W-1:0]          gen_count
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0]    X_MAX    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]    Y_MAX    = YW'(HEIGHT - 1);
    localparam logic [WIDTH-1:0] SEED_COL = WIDTH'(1) << SEED_X;

    gol_state_e       state_r;
    logic [WIDTH-1:0] grid_r [HEIGHT];
    logic [WIDTH-1:0] first_row_r;
    logic [WIDTH-1:0] prev_row_r;
    logic [YW-1:0]    y_r;
    logic             wrap_q_r;
    logic             pending_r;
    logic [DIV_W-1:0] rate_r;
    logic             gen_done_r;
    logic [GEN_W-1:0] gen_count_r;
    logic             rd_cell_r;

    logic [DIV_W-1:0] period_m1_s;
    logic             step_req_s;
    logic             wr_ok_s;
    logic [WIDTH-1:0] above_s;
    logic [WIDTH-1:0] cur_s;
    logic [WIDTH-1:0] below_s;
    logic [WIDTH-1:0] new_row_s;

    // Step request decode and neighbour-row selection for the row being updated.
    always_comb begin
        period_m1_s = (period == '0) ? '0 : period - DIV_W'(1);
        step_req_s  = step | (run & (rate_r >= period_m1_s));
        wr_ok_s     = (wr_x <= X_MAX) & (wr_y <= Y_MAX);
        cur_s       = grid_r[y_r];
        if ((y_r == '0) && !wrap_q_r) begin
            above_s = '0;
        end else begin
            above_s = prev_row_r;
        end
        if (y_r == Y_MAX) begin
            below_s = wrap_q_r ? first_row_r : '0;
        end else begin
            below_s = grid_r[y_r + YW'(1)];
        end
    end

    gol_row_rule #(.WIDTH(WIDTH)) u_row_rule (
        .above    (above_s),
        .cur      (cur_s),
        .below    (below_s),
        .wrap     (wrap_q_r),
        .next_row (new_row_s)
    );

    // Run-mode rate counter; idles at zero whenever run is low.
    always_ff @(posedge Clk) begin
        if (Reset || !run) begin
            rate_r <= '0;
        end else if (rate_r >= period_m1_s) begin
            rate_r <= '0;
        end else begin
            rate_r <= rate_r + DIV_W'(1);
        end
    end

    // Generation FSM, grid storage and host commands.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < HEIGHT; i++) grid_r[i] <= '0;
            state_r     <= IDLE;
            first_row_r <= '0;
            prev_row_r  <= '0;
            y_r         <= '0;
            wrap_q_r    <= 1'b0;
            pending_r   <= 1'b0;
            gen_done_r  <= 1'b0;
            gen_count_r <= '0;
        end else begin
            gen_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (clear) begin
                        for (int i = 0; i < HEIGHT; i++) grid_r[i] <= '0;
                        pending_r <= 1'b0;
                    end else if (seed) begin
                        for (int i = 0; i < HEIGHT; i++) grid_r[i] <= (i == SEED_Y) ? '1 : SEED_COL;
                        pending_r <= 1'b0;
                    end else if (wr_en) begin
                        if (wr_ok_s) grid_r[wr_y][wr_x] <= wr_data;
                        if (step_req_s) pending_r <= 1'b1;
                    end else if (step_req_s || pending_r) begin
                        first_row_r <= grid_r[0];
                        prev_row_r  <= grid_r[HEIGHT-1];
                        y_r         <= '0;
                        wrap_q_r    <= wrap;
                        pending_r   <= 1'b0;
                        state_r     <= UPDATE;
                    end
                end
                UPDATE: begin
                    grid_r[y_r] <= new_row_s;
                    prev_row_r  <= cur_s;
                    if (y_r == Y_MAX) begin
                        gen_done_r  <= 1'b1;
                        gen_count_r <= gen_count_r + GEN_W'(1);
                        // Back-to-back generation: row 0 is already new, the last row is new_row_s.
                        if (pending_r || step_req_s) begin
                            first_row_r <= grid_r[0];
                            prev_row_r  <= new_row_s;
                            y_r         <= '0;
                            wrap_q_r    <= wrap;
                            pending_r   <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        y_r <= y_r + YW'(1);
                        if (step_req_s) pending_r <= 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Registered pixel read; out-of-range coordinates read as dead.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_cell_r <= 1'b0;
        end else if ((rd_x <= X_MAX) && (rd_y <= Y_MAX)) begin
            rd_cell_r <= grid_r[rd_y][rd_x];
        end else begin
            rd_cell_r <= 1'b0;
        end
    end

    assign rd_cell   = rd_cell_r;
    assign busy      = (state_r == UPDATE);
    assign gen_done  = gen_done_r;
    assign gen_count = gen_count_r;

endmodule

// File: tb/tb_gol_engine.sv
// Scoreboarded bench for gol_engine: a plain-array Life model predicts each
// generation, a monitor checks gen_count on every gen_done pulse.
module tb_gol_engine;

    localparam int W  = 50;
    localparam int H  = 40;
    localparam int DW = 32;
    localparam int GW = 16;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          step = 1'b0, run = 1'b0, wrap = 1'b0;
    logic [DW-1:0] period = '0;
    logic          seed = 1'b0, clear = 1'b0, wr_en = 1'b0, wr_data = 1'b0;
    logic [XW-1:0] wr_x = '0, rd_x = '0;
    logic [YW-1:0] wr_y = '0, rd_y = '0;
    logic          rd_cell, busy, gen_done;
    logic [GW-1:0] gen_count;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];
    int exp_gen = 0;
    bit mdl [H][W];

    always #5 Clk = ~Clk;

    gol_engine #(.WIDTH(W), .HEIGHT(H), .DIV_W(DW), .GEN_W(GW)) dut (
        .Clk(Clk), .Reset(Reset), .step(step), .run(run), .period(period),
        .wrap(wrap), .seed(seed), .clear(clear), .wr_en(wr_en), .wr_x(wr_x),
        .wr_y(wr_y), .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y),
        .rd_cell(rd_cell), .busy(busy), .gen_done(gen_done), .gen_count(gen_count)
    );

    // Monitor: every gen_done must match the next expected generation number.
    always @(negedge Clk) begin
        int e;
        if (!Reset && gen_done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL gen_done_unexpected: got pulse with gen_count=%0d, required no pulse", gen_count);
            end else begin
                e = exp_q.pop_front();
                if (gen_count !== e[GW-1:0]) begin
                    n_fail++;
                    $display("FAIL gen_count: got %0d, required %0d", gen_count, e[GW-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) mdl[y][x] = 1'b0;
    endtask

    task automatic model_step(input bit w);
        bit nx [H][W];
        int n, yy, xx;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dy != 0 || dx != 0) begin
                            yy = y + dy;
                            xx = x + dx;
                            if (w) n += int'(mdl[(yy + H) % H][(xx + W) % W]);
                            else if (yy >= 0 && yy < H && xx >= 0 && xx < W) n += int'(mdl[yy][xx]);
                        end
                    end
                end
                nx[y][x] = (n == 3) || (mdl[y][x] && n == 2);
            end
        end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) mdl[y][x] = nx[y][x];
    endtask

    task automatic write_cell(input int x, input int y, input bit v);
        wr_en = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_data = v;
        tick();
        wr_en = 1'b0;
        if (x < W && y < H) mdl[y][x] = v;
    endtask

    task automatic read_cell(input int x, input int y, output bit v);
        rd_x = XW'(x); rd_y = YW'(y);
        tick();
        v = rd_cell;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_grid(input string name);
        int mism, fx, fy;
        mism = 0; fx = -1; fy = -1;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                rd_x = XW'(x); rd_y = YW'(y);
                tick();
                if (rd_cell !== mdl[y][x]) begin
                    if (mism == 0) begin fx = x; fy = y; end
                    mism++;
                end
            end
        end
        n_cmp++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d differing cells (first at x=%0d y=%0d), required 0", name, mism, fx, fy);
        end
    endtask

    // Waits for gen_done; counts elapsed cycles and busy cycles before it.
    task automatic wait_done(input int limit, output int elapsed, output int busy_cnt);
        elapsed = 0; busy_cnt = 0;
        for (int c = 0; c < limit; c++) begin
            tick();
            step = 1'b0;
            elapsed++;
            if (gen_done) return;
            if (busy) busy_cnt++;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL gen_done_timeout: got no pulse in %0d cycles, required one", limit);
    endtask

    task automatic do_gen(input bit w);
        int el, bc;
        model_step(w);
        exp_gen++;
        exp_q.push_back(exp_gen);
        wrap = w;
        step = 1'b1;
        wait_done(200, el, bc);
        check("gen_latency", el, H + 1);
        check("busy_cycles", bc, H);
    endtask

    task automatic load_glider();
        int gx[5] = '{49, 0, 48, 49, 0};
        int gy[5] = '{38, 39, 0, 0, 0};
        pulse_clear();
        model_clear();
        for (int i = 0; i < 5; i++) write_cell(gx[i], gy[i], 1'b1);
    endtask

    initial begin
        int el, bc;
        bit v;
        int dens;

        repeat (3) tick();
        check("reset_rd_cell", rd_cell, 0);
        check("reset_busy", busy, 0);
        check("reset_gen_done", gen_done, 0);
        check("reset_gen_count", gen_count, 0);
        Reset = 1'b0;
        model_clear();
        check_grid("reset_grid");

        // Blinker with dead border
        write_cell(5, 4, 1'b1); write_cell(5, 5, 1'b1); write_cell(5, 6, 1'b1);
        do_gen(1'b0);
        read_cell(4, 5, v); check("blinker_4_5", v, 1);
        read_cell(6, 5, v); check("blinker_6_5", v, 1);
        read_cell(5, 4, v); check("blinker_5_4", v, 0);
        check_grid("blinker_gen1");
        do_gen(1'b0);
        check_grid("blinker_gen2");
        check("blinker_count", gen_count, 2);

        // Seed, host write, out-of-range accesses
        seed = 1'b1; tick(); seed = 1'b0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) mdl[y][x] = (x == 10) || (y == 5);
        read_cell(10, 0, v); check("seed_10_0", v, 1);
        read_cell(0, 5, v);  check("seed_0_5", v, 1);
        read_cell(0, 0, v);  check("seed_0_0", v, 0);
        write_cell(0, 0, 1'b1);
        read_cell(0, 0, v);  check("write_0_0", v, 1);
        write_cell(55, 3, 1'b1);
        read_cell(55, 5, v); check("rd_x_out_of_range", v, 0);
        read_cell(3, 45, v); check("rd_y_out_of_range", v, 0);
        check_grid("seed_grid");
        check("seed_keeps_count", gen_count, 2);

        // Clear, seed and write during a generation are ignored
        model_step(1'b1); exp_gen++; exp_q.push_back(exp_gen);
        wrap = 1'b1; step = 1'b1; tick(); step = 1'b0;
        repeat (5) tick();
        pulse_clear();
        seed = 1'b1; tick(); seed = 1'b0;
        wr_en = 1'b1; wr_x = XW'(1); wr_y = YW'(1); wr_data = 1'b1; tick(); wr_en = 1'b0;
        wait_done(100, el, bc);
        check_grid("clear_busy_ignored");
        pulse_clear();
        model_clear();
        check_grid("clear_idle");

        // Write and step in the same cycle: generation sees the written cell
        write_cell(20, 19, 1'b1); write_cell(20, 21, 1'b1);
        mdl[20][20] = 1'b1;
        model_step(1'b0); exp_gen++; exp_q.push_back(exp_gen);
        wrap = 1'b0;
        wr_en = 1'b1; wr_x = XW'(20); wr_y = YW'(20); wr_data = 1'b1; step = 1'b1;
        tick();
        wr_en = 1'b0; step = 1'b0;
        wait_done(100, el, bc);
        check("wr_step_latency", el + 1, H + 2);
        check_grid("wr_step_grid");

        // Pending: three requests, exactly two generations
        model_step(1'b0); model_step(1'b0);
        exp_gen++; exp_q.push_back(exp_gen);
        exp_gen++; exp_q.push_back(exp_gen);
        for (int c = 0; c < 90; c++) begin
            step = (c == 0 || c == 5 || c == 10);
            tick();
        end
        step = 1'b0;
        repeat (50) tick();
        check("pending_count", gen_count, exp_gen);
        check_grid("pending_grid");

        // Random grids, random wrap
        for (int r = 0; r < 5; r++) begin
            pulse_clear();
            model_clear();
            dens = $urandom_range(15, 50);
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    if ($urandom_range(0, 99) < dens) write_cell(x, y, 1'b1);
            do_gen(1'($urandom_range(0, 1)));
            check_grid("random_grid");
        end

        // Glider across the corner, toroidal then bounded
        load_glider();
        for (int g = 0; g < 200; g++) do_gen(1'b1);
        check_grid("glider_wrap");
        load_glider();
        for (int g = 0; g < 60; g++) do_gen(1'b0);
        check_grid("glider_border");

        // Run mode, period 100, empty grid
        pulse_clear();
        model_clear();
        for (int i = 0; i < 3; i++) begin exp_gen++; exp_q.push_back(exp_gen); end
        period = DW'(100);
        run = 1'b1;
        wait_done(300, el, bc); check("run100_first", el, 100 + H);
        wait_done(300, el, bc); check("run100_interval", el, 100);
        wait_done(300, el, bc); check("run100_interval", el, 100);
        run = 1'b0;
        repeat (150) tick();

        // Run mode, period 0: back-to-back generations
        for (int i = 0; i < 4; i++) begin exp_gen++; exp_q.push_back(exp_gen); end
        period = '0;
        run = 1'b1;
        wait_done(100, el, bc); check("run0_first", el, H + 1);
        for (int i = 0; i < 2; i++) begin
            wait_done(100, el, bc);
            check("run0_interval", el, H);
            check("run0_busy_cont", bc, H - 1);
        end
        run = 1'b0;
        wait_done(100, el, bc); check("run0_tail", el, H);
        repeat (60) tick();
        check("run0_idle", busy, 0);
        check("run0_count", gen_count, exp_gen);

        // Reset while the engine is on row 17
        write_cell(3, 3, 1'b1); write_cell(4, 3, 1'b1);
        wrap = 1'b0; step = 1'b1; tick(); step = 1'b0;
        repeat (17) tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        exp_gen = 0;
        model_clear();
        check("midreset_busy", busy, 0);
        check("midreset_count", gen_count, 0);
        check("midreset_gen_done", gen_done, 0);
        repeat (60) tick();
        check_grid("midreset_grid");
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
